// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART types, constants and helpers for the RX and TX sides.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Default data width of a UART frame.
  localparam int UART_DATA_BITS = 8;

  // Receiver state encoding.
  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_IDLE = 3'd5
  } rx_state_t;

  // Even-parity bit of a data word. Narrower words are zero-extended by the
  // caller, which leaves the parity unchanged.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module  : uart_rx_sync
// Brief   : Two-flop synchronizer for the asynchronous rx line. Resets to 1
//           so that an idle line is seen during and right after reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Two-stage resynchronisation of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module  : uart_rx
// Brief   : UART receiver: start bit, DATA_BITS data bits (LSB first), even
//           parity bit, stop bit. Oversampled rx line, valid/ready output
//           holding register with parity, framing and overrun status.
//           Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling of
//           data, parity and stop bits around the bit centre.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int c_BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] c_IDLE      = RX_IDLE;
  localparam logic [2:0] c_START     = RX_START;
  localparam logic [2:0] c_DATA      = RX_DATA;
  localparam logic [2:0] c_PARITY    = RX_PARITY;
  localparam logic [2:0] c_STOP      = RX_STOP;
  localparam logic [2:0] c_WAIT_IDLE = RX_WAIT_IDLE;

  logic                 w_rx_s;
  logic                 w_bit;
  logic                 w_centre;
  logic                 w_frame_done;
  logic [2:0]           r_state;
  logic [c_CNT_W-1:0]   r_clk_cnt;
  logic [c_BIT_W-1:0]   r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (w_rx_s)
  );

  assign w_centre = (r_clk_cnt == c_CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_maj;

  // Capture the two early samples that precede the bit-centre decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_maj <= 2'b00;
    end else if (r_clk_cnt == c_CNT_W'(CLKS_PER_BIT - 3)) begin
      r_maj[0] <= w_rx_s;
    end else if (r_clk_cnt == c_CNT_W'(CLKS_PER_BIT - 2)) begin
      r_maj[1] <= w_rx_s;
    end
  end

  assign w_bit = (r_maj[0] & r_maj[1]) | (r_maj[0] & w_rx_s) | (r_maj[1] & w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  assign w_frame_done = (r_state == c_STOP) && w_centre;
  assign busy         = (r_state != c_IDLE);

  // Frame FSM with bit timing, data shifter and parity evaluation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_clk_cnt <= '0;
          if (!w_rx_s) r_state <= c_START;
        end
        c_START: begin
          if (r_clk_cnt == c_CNT_HALF) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            // A start bit that is high again at its centre is a glitch.
            r_state   <= w_rx_s ? c_IDLE : c_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        c_DATA: begin
          if (w_centre) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == c_BIT_LAST) r_state <= c_PARITY;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        c_PARITY: begin
          if (w_centre) begin
            r_clk_cnt <= '0;
            r_perr    <= w_bit ^ even_parity(UART_DATA_BITS'(r_shift));
            r_state   <= c_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        c_STOP: begin
          if (w_centre) begin
            r_clk_cnt <= '0;
            // A low stop bit may be a break; wait for the line to recover.
            r_state   <= w_bit ? c_IDLE : c_WAIT_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        c_WAIT_IDLE: begin
          if (w_rx_s) r_state <= c_IDLE;
        end
        default: begin
          r_state   <= c_IDLE;
          r_clk_cnt <= '0;
        end
      endcase
    end
  end

  // Output holding register: a new frame always wins over an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (w_frame_done) begin
      rx_data    <= r_shift;
      rx_valid   <= 1'b1;
      parity_err <= r_perr;
      frame_err  <= ~w_bit;
      overrun    <= rx_valid & ~rx_ready;
    end else if (rx_valid && rx_ready) begin
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Scoreboard bench for uart_rx at 16 clk per bit. Stimulus pushes
//           expected bytes; a negedge monitor pops them on each accept.
//           Honours UART_RX_MAJORITY_EN for the glitch-tolerance case.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          parity_err;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   valid_cycles = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame; rx is left at the stop value so callers can stretch a break.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int stop_len, input int glitch_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      if (i == glitch_bit) begin
        tick(8);
        rx = ~d[i];
        tick(1);
        rx = d[i];
        tick(CPB - 9);
      end else begin
        tick(CPB);
      end
    end
    rx = p;
    tick(CPB);
    rx = s;
    tick(stop_len);
  endtask

  // Monitor: every accepted byte must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) valid_cycles++;
      if (rx_valid && rx_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: actual=0x%0h required=none", rx_data);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("parity_err", 32'(parity_err), 32'(e.perr));
          check("frame_err", 32'(frame_err), 32'(e.ferr));
          check("overrun", 32'(overrun), 32'(e.ovr));
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(3);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_flags", 32'({parity_err, frame_err, overrun}), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(4);

    // 1: clean 0xA5, single-cycle valid
    valid_cycles = 0;
    sb_q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_frame(8'hA5, 1'b0, 1'b1, CPB, -1);
    tick(CPB);
    check("valid_one_cycle", 32'(valid_cycles), 32'd1);

    // 2: wrong parity on 0x01
    sb_q.push_back('{data: 8'h01, perr: 1'b1, ferr: 1'b0, ovr: 1'b0});
    send_frame(8'h01, 1'b0, 1'b1, CPB, -1);
    tick(CPB);

    // 3: framing error with break, then clean 0x55
    sb_q.push_back('{data: 8'h7E, perr: 1'b0, ferr: 1'b1, ovr: 1'b0});
    send_frame(8'h7E, 1'b0, 1'b0, 40, -1);
    check("busy_in_break", 32'(busy), 32'h1);
    rx = 1'b1;
    tick(6);
    check("busy_after_break", 32'(busy), 32'h0);
    sb_q.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_frame(8'h55, 1'b0, 1'b1, CPB, -1);
    tick(CPB);

    // 4: short start glitch
    valid_cycles = 0;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    check("glitch_no_valid", 32'(valid_cycles), 32'd0);
    check("glitch_idle", 32'(busy), 32'h0);

    // 5: overrun
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, CPB, -1);
    tick(CPB);
    send_frame(8'hC3, 1'b0, 1'b1, CPB, -1);
    tick(CPB);
    check("ovr_valid", 32'(rx_valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_data", 32'(rx_data), 32'hC3);
    sb_q.push_back('{data: 8'hC3, perr: 1'b0, ferr: 1'b0, ovr: 1'b1});
    rx_ready = 1'b1;
    tick(2);
    check("ovr_valid_cleared", 32'(rx_valid), 32'h0);
    check("ovr_flag_cleared", 32'(overrun), 32'h0);

    // 6: reset in the 4th data bit, then 0x5A
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB + 8);
    rst = 1'b1;
    tick(2);
    check("midreset_rx_data", 32'(rx_data), 32'h0);
    check("midreset_rx_valid", 32'(rx_valid), 32'h0);
    check("midreset_flags", 32'({parity_err, frame_err, overrun}), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(CPB);
    sb_q.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h5A, 1'b0, 1'b1, CPB, 1);
`else
    send_frame(8'h5A, 1'b0, 1'b1, CPB, -1);
`endif
    tick(CPB);

    // Drain with a bounded wait
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) tick(1);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
